// File: rtl/simple_hardware_timer_core.sv
// Prescaled down-counter with periodic/one-shot reload, sticky status and level irq.
// Optional capture unit built when SIMPLE_HARDWARE_TIMER_CAPTURE_EN is defined.
module simple_hardware_timer_core #(
  parameter int CNT_WIDTH      = 32,
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                      s00_axi_aclk,
  input  logic                      s00_axi_aresetn,
  input  logic                      ctrl_enable,
  input  logic                      ctrl_oneshot,
  input  logic                      ctrl_irq_en,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic [CNT_WIDTH-1:0]      period,
  input  logic                      load_pulse,
  input  logic                      status_clear,
  input  logic                      capture_in,
  output logic [CNT_WIDTH-1:0]      count,
  output logic                      running,
  output logic                      expired,
  output logic                      overrun,
  output logic                      irq,
  output logic [CNT_WIDTH-1:0]      capture_val,
  output logic                      capture_valid
);

  logic                      enable_q;
  logic [PRESCALE_WIDTH-1:0] prescaler;
  logic                      start;
  logic                      tick;
  logic                      expiry;

  // load_pulse and status_clear are single-cycle strobes with no ready/ack;
  // the core acts on them in the cycle they are high. Start outranks a tick.
  always_comb begin
    start  = ctrl_enable & (~enable_q | load_pulse);
    tick   = running & ctrl_enable & ~start & (prescaler >= prescale);
    expiry = tick & (count == '0);
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      enable_q  <= 1'b0;
      count     <= '0;
      prescaler <= '0;
      running   <= 1'b0;
    end else begin
      enable_q <= ctrl_enable;
      if (start) begin
        count     <= period;
        prescaler <= '0;
        running   <= 1'b1;
      end else if (load_pulse) begin
        count     <= period;
        prescaler <= '0;
        running   <= 1'b0;
      end else if (!ctrl_enable) begin
        prescaler <= '0;
        running   <= 1'b0;
      end else if (running) begin
        // >= keeps a mid-run prescale decrease from stalling the divider
        if (prescaler >= prescale) begin
          prescaler <= '0;
          if (count == '0) begin
            count <= period;
            if (ctrl_oneshot) running <= 1'b0;
          end else begin
            count <= count - 1'b1;
          end
        end else begin
          prescaler <= prescaler + 1'b1;
        end
      end
    end
  end

  // Set beats a coincident clear.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      expired <= 1'b0;
      overrun <= 1'b0;
    end else begin
      expired <= expiry | (expired & ~status_clear);
      overrun <= (expiry & expired) | (overrun & ~status_clear);
    end
  end

  assign irq = expired & ctrl_irq_en;

`ifdef SIMPLE_HARDWARE_TIMER_CAPTURE_EN
  logic [2:0] cap_sync;
  logic       cap_rise;

  assign cap_rise = cap_sync[1] & ~cap_sync[2];

  // Two synchronizer flops plus one history flop for edge detect.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      cap_sync      <= '0;
      capture_val   <= '0;
      capture_valid <= 1'b0;
    end else begin
      cap_sync      <= {cap_sync[1:0], capture_in};
      capture_valid <= cap_rise | (capture_valid & ~status_clear);
      if (cap_rise) capture_val <= count;
    end
  end
`else
  logic unused_capture;
  assign unused_capture = capture_in;
  assign capture_val    = '0;
  assign capture_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_simple_hardware_timer_core.sv
// Bench for simple_hardware_timer_core: directed scenarios plus random stimulus,
// scored against a closed-form timeline model through an expected queue.
module tb_simple_hardware_timer_core;
  localparam int CW = 32;
  localparam int PW = 16;
  localparam int W  = 2*CW + 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ctrl_enable, ctrl_oneshot, ctrl_irq_en;
  logic [PW-1:0] prescale;
  logic [CW-1:0] period;
  logic          load_pulse, status_clear, capture_in;
  logic [CW-1:0] count, capture_val;
  logic          running, expired, overrun, irq, capture_valid;

  always #5 clk = ~clk;

  simple_hardware_timer_core #(.CNT_WIDTH(CW), .PRESCALE_WIDTH(PW)) dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
    .ctrl_enable(ctrl_enable), .ctrl_oneshot(ctrl_oneshot), .ctrl_irq_en(ctrl_irq_en),
    .prescale(prescale), .period(period), .load_pulse(load_pulse),
    .status_clear(status_clear), .capture_in(capture_in),
    .count(count), .running(running), .expired(expired), .overrun(overrun),
    .irq(irq), .capture_val(capture_val), .capture_valid(capture_valid)
  );

  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;
  int tests = 0;
  int fails = 0;

  // Reference model: a run segment is described by its start edge and the
  // configuration latched then; outputs follow from elapsed-edge arithmetic.
  bit        en_q_m, seg_on, seg_os, cap_prev;
  longint    seg_start, seg_pd, seg_ps, k;
  logic [CW-1:0] cnt_m, capval_m;
  bit        run_m, exp_m, ovr_m, capv_m;
  longint    capdue_q[$];

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    en_q_m = 0; seg_on = 0; seg_os = 0; cap_prev = 0;
    seg_start = 0; seg_pd = 0; seg_ps = 0; k = 0;
    cnt_m = '0; capval_m = '0;
    run_m = 0; exp_m = 0; ovr_m = 0; capv_m = 0;
    capdue_q.delete();
  endtask

  task automatic model_edge();
    longint d, t;
    bit start, expiry, hit;
    logic [CW-1:0] old_cnt;
    old_cnt = cnt_m;
    expiry  = 0;
    hit     = 0;
    if (capture_in && !cap_prev) capdue_q.push_back(k + 2);
    cap_prev = capture_in;
    if (capdue_q.size() > 0 && capdue_q[0] == k) begin
      hit = 1;
      void'(capdue_q.pop_front());
    end
    start = ctrl_enable && (!en_q_m || load_pulse);
    if (start) begin
      seg_on = 1; seg_start = k; seg_pd = longint'(period);
      seg_ps = longint'(prescale); seg_os = ctrl_oneshot;
    end else if (load_pulse) begin
      seg_on = 0; cnt_m = period;
    end else if (!ctrl_enable) begin
      seg_on = 0;
    end else if (seg_on) begin
      d = k - seg_start;
      t = d / (seg_ps + 1);
      expiry = d > 0 && (d % (seg_ps + 1)) == 0 && (t % (seg_pd + 1)) == 0 &&
               (!seg_os || t == seg_pd + 1);
    end
    if (seg_on) begin
      d = k - seg_start;
      t = d / (seg_ps + 1);
      if (seg_os && t >= seg_pd + 1) begin
        cnt_m = CW'(seg_pd); run_m = 0;
      end else begin
        cnt_m = CW'(seg_pd - (t % (seg_pd + 1))); run_m = 1;
      end
    end else begin
      run_m = 0;
    end
    ovr_m = (expiry && exp_m) || (ovr_m && !status_clear);
    exp_m = expiry || (exp_m && !status_clear);
`ifdef SIMPLE_HARDWARE_TIMER_CAPTURE_EN
    if (hit) capval_m = old_cnt;
    capv_m = hit || (capv_m && !status_clear);
`else
    capval_m = '0;
    capv_m   = 0;
`endif
    en_q_m = ctrl_enable;
    exp_q.push_back({cnt_m, run_m, exp_m, ovr_m, exp_m & ctrl_irq_en, capval_m, capv_m});
    k++;
  endtask

  // Monitor: every edge out of reset the DUT presents a full output set.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("count",         count,               mon_e[W-1 -: CW]);
        check("running",       32'(running),        32'(mon_e[CW+4]));
        check("expired",       32'(expired),        32'(mon_e[CW+3]));
        check("overrun",       32'(overrun),        32'(mon_e[CW+2]));
        check("irq",           32'(irq),            32'(mon_e[CW+1]));
        check("capture_val",   capture_val,         mon_e[CW:1]);
        check("capture_valid", 32'(capture_valid),  32'(mon_e[0]));
      end
    end
  end

  task automatic cyc(input bit en, input bit lp, input bit clr, input bit cap);
    @(negedge clk);
    ctrl_enable = en; load_pulse = lp; status_clear = clr; capture_in = cap;
    model_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic set_cfg(input int pd, input int ps, input bit os, input bit ie);
    period = CW'(pd); prescale = PW'(ps); ctrl_oneshot = os; ctrl_irq_en = ie;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_count"},   count,              32'd0);
    check({tag, "_running"}, 32'(running),       32'd0);
    check({tag, "_expired"}, 32'(expired),       32'd0);
    check({tag, "_overrun"}, 32'(overrun),       32'd0);
    check({tag, "_irq"},     32'(irq),           32'd0);
    check({tag, "_capval"},  capture_val,        32'd0);
    check({tag, "_capvld"},  32'(capture_valid), 32'd0);
  endtask

  task automatic release_reset();
    ctrl_enable = 0; load_pulse = 0; status_clear = 0; capture_in = 0;
    @(negedge clk);
    rst_n = 1;
    model_reset();
    @(posedge clk);
    #2;
  endtask

  task automatic mid_run_reset();
    rst_n = 0;
    #1;
    check_all_zero("midrst");
    ctrl_enable = 0; load_pulse = 0; status_clear = 0; capture_in = 0;
    repeat (2) @(negedge clk);
    check_all_zero("midrst_hold");
    release_reset();
  endtask

  bit en;
  int guard;

  initial begin
    rst_n = 0;
    set_cfg(0, 0, 0, 0);
    ctrl_enable = 0; load_pulse = 0; status_clear = 0; capture_in = 0;
    model_reset();
    // 200 ns of reset with inputs toggling
    repeat (20) begin
      #10;
      ctrl_enable  = 1'($urandom_range(0, 1)); load_pulse = 1'($urandom_range(0, 1));
      status_clear = 1'($urandom_range(0, 1)); capture_in = 1'($urandom_range(0, 1));
      ctrl_irq_en  = 1'($urandom_range(0, 1)); period     = $urandom;
      #1;
      check_all_zero("rst");
    end
    set_cfg(0, 0, 0, 0);
    release_reset();
    repeat (2) cyc(0, 0, 0, 0);

    // Periodic, period 3: expiries at E4, E8 (overrun), E12 with clear, E16 masked
    set_cfg(3, 0, 0, 1);
    repeat (12) cyc(1, 0, 0, 0);
    cyc(1, 0, 1, 0);
    cyc(1, 0, 1, 0);
    ctrl_irq_en = 0;
    repeat (4) cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 0);

    // Prescaled one-shot, then load_pulse restart
    set_cfg(1, 4, 1, 1);
    repeat (14) cyc(1, 0, 0, 0);
    cyc(1, 1, 1, 0);
    repeat (12) cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 0);

    // Disable at count 57, hold, re-enable reloads
    set_cfg(100, 0, 0, 1);
    cyc(1, 0, 0, 0);
    guard = 0;
    while (cnt_m != 57 && guard < 200) begin
      cyc(1, 0, 0, 0);
      guard++;
    end
    check("reach_57", cnt_m, 32'd57);
    repeat (3) cyc(0, 0, 0, 0);
    repeat (3) cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);

    // Capture while counting down from 50
    set_cfg(50, 0, 0, 1);
    repeat (6) cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 1);
    repeat (5) cyc(1, 0, 0, 0);
    cyc(1, 0, 1, 0);
    cyc(0, 0, 0, 0);

    // Period 0: expiry on every tick
    set_cfg(0, 1, 0, 1);
    repeat (8) cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 0);

    // Random phase with one asynchronous reset mid-run
    en = 0;
    for (int i = 0; i < 2500; i++) begin
      bit lp, clr, cap;
      if (i == 1200) begin
        mid_run_reset();
        en = 0;
      end
      lp  = ($urandom_range(0, 29) == 0);
      clr = ($urandom_range(0, 7) == 0);
      cap = ($urandom_range(0, 3) == 0) ? ~capture_in : capture_in;
      if (!en) begin
        if ($urandom_range(0, 2) == 0) en = 1;
        else if ($urandom_range(0, 1) == 1)
          set_cfg(($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 12)),
                  int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else if ($urandom_range(0, 79) == 0) begin
        en = 0;
      end
      if ($urandom_range(0, 19) == 0) ctrl_irq_en = ~ctrl_irq_en;
      cyc(en, lp, clr, cap);
    end

    @(posedge clk);
    #2;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/simple_hardware_timer_core.md
# simple_hardware_timer_core

Counting engine behind the `simple_hardware_timer` AXI4-Lite register slave. It consumes the control, prescale and period fields decoded by the register block, and runs a prescaled down-counter with periodic or one-shot reload. It returns the live count, sticky status bits and a level interrupt to the register block and the PS interrupt line. An optional capture unit latches the count on an external event.

## Interface
- CNT_WIDTH, 32, width of period and counter
- PRESCALE_WIDTH, 16, width of prescale divider
- s00_axi_aclk  in  1  sole clock, same as register slave
- s00_axi_aresetn  in  1  asynchronous active-low reset
- ctrl_enable  in  1  run enable (level)
- ctrl_oneshot  in  1  1 = stop after first expiry, 0 = periodic
- ctrl_irq_en  in  1  interrupt mask
- prescale  in  PRESCALE_WIDTH  tick divider; tick every prescale+1 clocks
- period  in  CNT_WIDTH  reload value; expiry every period+1 ticks
- load_pulse  in  1  one-cycle strobe: force reload
- status_clear  in  1  one-cycle strobe: clear expired, overrun, capture_valid
- capture_in  in  1  asynchronous external capture event
- count  out  CNT_WIDTH  current counter value
- running  out  1  counter actively decrementing
- expired  out  1  sticky expiry flag
- overrun  out  1  sticky: expiry while expired already set
- irq  out  1  expired & ctrl_irq_en, combinational from registers
- capture_val  out  CNT_WIDTH  count latched at capture event
- capture_valid  out  1  sticky capture flag

## Operation
- Reset values: count=0, prescaler=0, running=0, expired=0, overrun=0, capture_val=0, capture_valid=0, internal enable_q=0, irq=0.
- Start happens on an enable rising edge (ctrl_enable=1, enable_q=0), or on load_pulse while ctrl_enable=1. On start: count<=period, prescaler<=0, running<=1.
- load_pulse with ctrl_enable=0: count<=period, prescaler<=0, running stays 0.
- ctrl_enable=0: running<=0, prescaler<=0, count holds.
- While running:
  - If prescaler>=prescale, a tick occurs and prescaler<=0. Otherwise prescaler increments.
  - The `>=` comparison keeps a prescale decrease mid-run safe.
- On a tick:
  - If count!=0: count<=count-1.
  - If count==0: expiry. count<=period; expired<=1; overrun<=1 if expired was already 1; if ctrl_oneshot then running<=0.
- One-shot restart requires an enable 0->1 transition or load_pulse.
- Changes to period take effect at the next reload only.
- Status priority: a set (expiry or capture) in the same cycle as status_clear wins, so the flag stays 1. Overrun set and clear in the same cycle resolves the same way.
- Start and load_pulse have priority over a coincident tick; no expiry is generated in that cycle.
- Counter arithmetic is unsigned CNT_WIDTH. It never wraps below 0; count==0 always triggers reload.

## Timing
- Start registered at edge E0 gives count=period after E0.
- With prescale=P, the first expiry is at edge E0+(period+1)*(P+1). expired is visible after that edge. Subsequent expiries follow every (period+1)*(P+1) clocks.
- irq follows expired/ctrl_irq_en with zero added latency.
- status_clear at edge E takes flags low after E unless a set occurs at E.
- Capture latency: 2-flop synchronizer plus edge detect. capture_val and capture_valid update 3 edges after a capture_in rise that meets setup. The captured value is the count at that update edge.
- Asynchronous reset mid-run returns all state to reset values immediately. Operation resumes only on a new start after reset deassertion.

## Configuration
- SIMPLE_HARDWARE_TIMER_CAPTURE_EN defined: synchronizer, edge detect and capture registers are built as described.
- Macro undefined: ports remain, capture_in is ignored, and capture_val=0 and capture_valid=0 constantly. status_clear affects only expired and overrun.

## Test plan
- Reset: hold aresetn low 200 ns with inputs toggling. Required response: all outputs 0; after release, count=0 and running=0.
- Periodic: prescale=0, period=3, enable rises at E0. Required response: count 3,2,1,0 then reload; expired rises after E4 and again due at E8. Leave expired uncleared across E8 and check overrun=1 after E8.
- Prescaled one-shot: prescale=4, period=1, oneshot=1. Required response: expiry after edge E0+10, running=0, count=1 and held. load_pulse restarts; next expiry 10 clocks later.
- Clear priority: status_clear on the same edge as an expiry. Required response: expired stays 1. status_clear alone on the next cycle gives expired=0 and irq=0. With ctrl_irq_en=0, irq stays 0 while expired=1.
- Disable mid-run: period=100, prescale=0, drop enable at count=57. Required response: count holds 57, running=0. Re-enable reloads count to 100.
- Capture (macro on): pulse capture_in while count is decrementing from 50. Required response: capture_val equals count 3 edges later, capture_valid=1. Macro off: capture_valid stays 0.
